multi_cycle_control: RTL
========================

# multi_cycle_control

Multi-cycle main control FSM for the MIPS subset (R-type, ori, lw, sw, beq, j), successor to the single-cycle `mainControl`. It sequences each instruction through fetch/decode/execute/memory/writeback states and drives the shared-datapath enables. It supports a ready/valid-style wait on instruction and data memory, a retired-instruction counter and a sticky illegal-opcode flag. It sits between the instruction register's opcode field and the multi-cycle datapath.

## Interface
- `ALUOP_W`, 3: width of `ALUop`; must be ≥3.
- `CNT_W`, 32: width of `instret`.
- `HAS_MEM_HANDSHAKE`, 1: when 0, `memReady` is ignored and treated as 1.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `OP` in 6: opcode from instruction register.
- `zero` in 1: ALU zero flag. Informational only; the datapath combines it with `pcWriteCond`.
- `memReady` in 1: memory completes the current read or write this cycle.
- `pcWrite`, `pcWriteCond`, `irWrite`, `iorD`, `memRead`, `memWrite`, `memToReg`, `regWrite`, `regDst`, `extop`, `ALUsrcA` out 1 each: datapath enables and selects.
- `ALUsrcB` out 2: 00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- `pcSource` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `ALUop` out `ALUOP_W`: ADD=0, SUB=1, OR=2, FUNCT=4 (R-type decodes funct).
- `state` out 4: current state, for debug.
- `instret` out `CNT_W`: retired-instruction count.
- `illegal` out 1: sticky flag for an unknown opcode.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - EXE_R=6, WB_R=7, EXE_I=8, WB_I=9, BRANCH=10, JUMP=11
- Outputs are Moore. All outputs default to 0 except where a state listed below sets them.
- FETCH: memRead=1, ALUsrcB=01, ALUop=ADD. `irWrite`=`pcWrite`=`memReady`. Stays in FETCH until `memReady`, then goes to DECODE.
- DECODE: ALUsrcB=11, extop=1, ALUop=ADD. Next state by `OP`:
  - 000000 → EXE_R
  - 001101 → EXE_I
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → FETCH and set `illegal`.
- MEM_ADDR: ALUsrcA=1, ALUsrcB=10, extop=1, ALUop=ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: memRead=1, iorD=1. Holds until `memReady`, then goes to MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, regDst=0. Goes to FETCH.
- MEM_WR: memWrite=1, iorD=1. Holds until `memReady`, then goes to FETCH.
- EXE_R: ALUsrcA=1, ALUsrcB=00, ALUop=FUNCT. Goes to WB_R.
- WB_R: regWrite=1, regDst=1. Goes to FETCH.
- EXE_I: ALUsrcA=1, ALUsrcB=10, extop=0, ALUop=OR. Goes to WB_I.
- WB_I: regWrite=1, regDst=0. Goes to FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUop=SUB, pcWriteCond=1, pcSource=01. Goes to FETCH.
- JUMP: pcWrite=1, pcSource=10. Goes to FETCH.
- `instret` increments (mod 2^CNT_W) on the final cycle of each instruction:
  - MEM_WB, WB_R, WB_I, BRANCH, JUMP
  - MEM_WR only in the cycle `memReady`=1
  - Illegal opcodes do not retire.
- `illegal` is set by an illegal DECODE and is cleared only by reset.

## Timing
- State, `instret` and `illegal` update on the rising edge of `clk`.
- Reset (`rst_n`=0), asynchronous and immediate:
  - state=FETCH, instret=0, illegal=0.
  - `pcWrite` and `irWrite` are forced 0 while `rst_n`=0.
  - All other outputs take their FETCH values: memRead=1, ALUsrcB=01, ALUop=ADD.
- Reset asserted mid-instruction abandons the instruction with no retire. The first fetch starts on the first edge after `rst_n` rises.
- Cycles per instruction with `memReady` tied 1:
  - R, ori: 4
  - lw: 5
  - sw: 4
  - beq, j: 3
  - illegal: 2
- Each cycle of `memReady`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Control outputs stay stable through the wait.
- `memRead`/`memWrite` stay asserted from state entry until the ready cycle.

## Structure
- Package `ctl_pkg`: opcode constants, `ALUop` codes, the 4-bit state enum, and the `ALUsrcB`/`pcSource` encodings.
- No sub-module: one FSM with next-state logic, a Moore output decode, and an inline counter.

## Test plan
- Reset then OP=000000, memReady=1 → states 0,1,6,7,0. regWrite=1 and regDst=1 only in WB_R. instret=1.
- OP=100011 with memReady low for 2 cycles in MEM_RD → 7 cycles total. memRead held for 3 cycles. memToReg=1 in MEM_WB. instret+1.
- OP=101011 with memReady=1 → memWrite=1 for exactly 1 cycle. Back in FETCH after 4 cycles. regWrite never 1.
- OP=000100 then OP=000010 → BRANCH has pcWriteCond=1, pcSource=01, ALUop=1. JUMP has pcWrite=1, pcSource=10. instret+2.
- OP=111111 → DECODE→FETCH, illegal=1 and stays 1, instret unchanged. `rst_n` pulse clears illegal.
- `rst_n`=0 asserted in MEM_RD → state=0 immediately, instret=0, pcWrite/irWrite=0 during reset. With HAS_MEM_HANDSHAKE=0 and memReady=0, lw still takes 5 cycles.

Source files
------------

// File: rtl/ctl_pkg.sv
// ctl_pkg: shared definitions for the multi-cycle MIPS main control.
// Holds opcode constants, ALU operation codes, the ALUsrcB / pcSource
// select encodings, the FSM state enum and a small opcode-legality helper.
`timescale 1ns/1ps
package ctl_pkg;

    // Opcodes of the supported MIPS subset
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes (FUNCT hands decoding over to the funct field)
    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_OR    = 3'd2;
    localparam logic [2:0] ALUOP_FUNCT = 3'd4;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXE_R    = 4'd6,
        ST_WB_R     = 4'd7,
        ST_EXE_I    = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    // True when the opcode belongs to the supported subset
    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: main control FSM of the multi-cycle MIPS datapath.
// Sequences R-type, ori, lw, sw, beq and j through fetch / decode /
// execute / memory / writeback and drives the shared-datapath controls.
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   OP             - opcode field of the instruction register
//   zero           - ALU zero flag (consumed by the datapath, not here)
//   memReady       - memory completes the pending access this cycle
//   pcWrite .. ALUsrcA, ALUsrcB, pcSource, ALUop - Moore datapath controls
//   state          - current FSM state for debug
//   instret        - retired-instruction counter (wraps)
//   illegal        - sticky unknown-opcode flag, cleared only by reset
`timescale 1ns/1ps
module multi_cycle_control
    import ctl_pkg::*;
#(
    parameter int ALUOP_W           = 3,
    parameter int CNT_W             = 32,
    parameter int HAS_MEM_HANDSHAKE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         OP,
    input  logic               zero,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               irWrite,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               memToReg,
    output logic               regWrite,
    output logic               regDst,
    output logic               extop,
    output logic               ALUsrcA,
    output logic [1:0]         ALUsrcB,
    output logic [1:0]         pcSource,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   instret,
    output logic               illegal
);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] instret_r;
    logic             illegal_r;
    logic             retire_s;
    logic             set_illegal_s;
    logic             mem_ready_s;
    logic             pc_write_s;
    logic             ir_write_s;
    logic [2:0]       aluop_s;
    logic             unused_zero_s;

    // The branch decision is made in the datapath from zero and pcWriteCond
    assign unused_zero_s = zero;

    // Without a handshake the memory is assumed to answer in one cycle
    assign mem_ready_s = (HAS_MEM_HANDSHAKE != 0) ? memReady : 1'b1;

    // Next-state decode plus retire / illegal-opcode events
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        set_illegal_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready_s) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (OP)
                    OP_RTYPE:      next_state_s = ST_EXE_R;
                    OP_ORI:        next_state_s = ST_EXE_I;
                    OP_LW, OP_SW:  next_state_s = ST_MEM_ADDR;
                    OP_BEQ:        next_state_s = ST_BRANCH;
                    OP_J:          next_state_s = ST_JUMP;
                    default: begin
                        // Unknown opcode: abandon without retiring
                        next_state_s  = ST_FETCH;
                        set_illegal_s = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                if (OP == OP_SW) begin
                    next_state_s = ST_MEM_WR;
                end else begin
                    next_state_s = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (mem_ready_s) begin
                    next_state_s = ST_MEM_WB;
                end else begin
                    next_state_s = ST_MEM_RD;
                end
            end
            ST_MEM_WB: begin
                next_state_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_MEM_WR: begin
                // A store retires only in the cycle its write completes
                if (mem_ready_s) begin
                    next_state_s = ST_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = ST_MEM_WR;
                end
            end
            ST_EXE_R:  next_state_s = ST_WB_R;
            ST_WB_R: begin
                next_state_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_EXE_I:  next_state_s = ST_WB_I;
            ST_WB_I: begin
                next_state_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_BRANCH, ST_JUMP: begin
                next_state_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            default:   next_state_s = ST_FETCH;
        endcase
    end

    // State register, retire counter and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            instret_r <= {CNT_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1);
            end else begin
                instret_r <= instret_r;
            end
            if (set_illegal_s) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    // Moore output decode; everything not set by a state stays 0
    always_comb begin
        pc_write_s  = 1'b0;
        pcWriteCond = 1'b0;
        ir_write_s  = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        extop       = 1'b0;
        ALUsrcA     = 1'b0;
        ALUsrcB     = SRCB_REG;
        pcSource    = PCSRC_ALU;
        aluop_s     = ALUOP_ADD;
        case (state_r)
            ST_FETCH: begin
                // PC+4 and the IR are captured only when the fetch completes
                memRead    = 1'b1;
                ALUsrcB    = SRCB_FOUR;
                aluop_s    = ALUOP_ADD;
                pc_write_s = mem_ready_s;
                ir_write_s = mem_ready_s;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                ALUsrcB = SRCB_IMM_SH;
                extop   = 1'b1;
                aluop_s = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
                extop   = 1'b1;
                aluop_s = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            ST_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                regDst   = 1'b0;
            end
            ST_MEM_WR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            ST_EXE_R: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_REG;
                aluop_s = ALUOP_FUNCT;
            end
            ST_WB_R: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            ST_EXE_I: begin
                // ori zero-extends its immediate
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
                extop   = 1'b0;
                aluop_s = ALUOP_OR;
            end
            ST_WB_I: begin
                regWrite = 1'b1;
                regDst   = 1'b0;
            end
            ST_BRANCH: begin
                ALUsrcA     = 1'b1;
                ALUsrcB     = SRCB_REG;
                aluop_s     = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write_s = 1'b1;
                pcSource   = PCSRC_JUMP;
            end
            default: begin
                aluop_s = ALUOP_ADD;
            end
        endcase
    end

    // PC and IR writes must never fire while reset is held
    assign pcWrite = pc_write_s & rst_n;
    assign irWrite = ir_write_s & rst_n;
    assign ALUop   = ALUOP_W'(aluop_s);
    assign state   = state_r;
    assign instret = instret_r;
    assign illegal = illegal_r;

endmodule
